div_unit: RTL and testbench

- Multi-cycle 32-bit divider for DIV/DIVU, one result bit per cycle (radix-2 restoring).
- Sits in EX, directly upstream of the HI/LO register file.
- Produces quotient (to LO) and remainder (to HI) with a one-cycle valid pulse, which the datapath turns into a HI+LO write.
- Drives busy so hazard control stalls the pipeline while a divide is in flight.

---
 rtl/div_unit.sv | 149 ++++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring 32-bit DIV/DIVU unit feeding the HI/LO register file
// One quotient bit per cycle; signs are stripped on entry and reapplied when the result is registered.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_comb begin
        a_mag  = (signed_div && opa[WIDTH-1]) ? -opa : opa;
        b_mag  = (signed_div && opb[WIDTH-1]) ? -opb : opb;
        // Shifted remainder can exceed WIDTH bits when the divisor is above 2^(WIDTH-1).
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
        rem_nx = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !annul) begin
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    cnt_d   = '0;
                    q_neg_d = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    r_neg_d = signed_div & opa[WIDTH-1];
                    if (opb != '0) begin
                        state_d = CALC;
                    end else begin
                        // Divide-by-zero returns all-ones quotient and the raw dividend.
                        state_d = DONE;
                        valid_d = 1'b1;
                        lo_d    = '1;
                        hi_d    = opa;
                    end
                end
            end
            CALC: begin
                if (annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        lo_d    = q_neg_q ? -quo_nx : quo_nx;
                        hi_d    = r_neg_q ? -rem_nx : rem_nx;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // A squash arriving during DONE must suppress the HI/LO write in that same cycle.
    assign busy         = busy_q;
    assign result_valid = valid_q & ~annul;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit against a 64-bit arithmetic reference
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        annul = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_div   (signed_div),
        .opa          (opa),
        .opb          (opb),
        .annul        (annul),
        .busy         (busy),
        .result_valid (result_valid),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          issue_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          valid_cnt = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint na, nb, q, r;
        e.issue_cyc = 0;
        if (b == 32'd0) begin
            e.lo  = 32'hFFFF_FFFF;
            e.hi  = a;
            e.lat = 1;
        end else begin
            if (sgn) begin
                na = $signed(a);
                nb = $signed(b);
            end else begin
                na = {32'd0, a};
                nb = {32'd0, b};
            end
            q     = na / nb;
            r     = na % nb;
            e.lo  = q[31:0];
            e.hi  = r[31:0];
            e.lat = 33;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && result_valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid lo=%h hi=%h", lo_out, hi_out);
            end else begin
                mon_e = sb.pop_front();
                chk("lo_out", lo_out, mon_e.lo);
                chk("hi_out", hi_out, mon_e.hi);
                chk("latency", 32'(cyc - mon_e.issue_cyc), 32'(mon_e.lat));
                last_lo = mon_e.lo;
                last_hi = mon_e.hi;
            end
        end
    end

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
        exp_t e;
        int   n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout busy=%b required=0", busy);
        end
        start      = 1'b1;
        signed_div = sgn;
        opa        = a;
        opb        = b;
        if (expect_it) begin
            e           = model(sgn, a, b);
            e.issue_cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        start      = 1'b0;
        signed_div = 1'($urandom_range(0, 1));
        opa        = $urandom;
        opb        = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL done_timeout busy=%b pending=%0d required=0", busy, sb.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int bc;
        logic       sgn;
        logic [31:0] a, b;

        #2 rst = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_hi", hi_out, 32'd0);
        chk("reset_lo", lo_out, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        issue(1'b0, 32'd100, 32'd7, 1'b1);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_cycles", bc, 32'd33);
        wait_done();

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        issue(1'b0, 32'h1234_5678, 32'd0, 1'b1);
        issue(1'b1, 32'h1234_5678, 32'd0, 1'b1);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done();

        v0 = valid_cnt;
        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_busy", {31'd0, busy}, 32'd0);
        chk("annul_lo_hold", lo_out, last_lo);
        chk("annul_hi_hold", hi_out, last_hi);
        issue(1'b0, 32'd100, 32'd7, 1'b1);
        wait_done();
        chk("annul_valid_count", 32'(valid_cnt - v0), 32'd1);

        v0 = valid_cnt;
        issue(1'b0, 32'd100, 32'd7, 1'b1);
        repeat (5) @(negedge clk);
        start = 1'b1;
        opa   = 32'd9;
        opb   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("busy_start_valid_count", 32'(valid_cnt - v0), 32'd1);

        issue(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_valid", {31'd0, result_valid}, 32'd0);
        chk("async_rst_hi", hi_out, 32'd0);
        chk("async_rst_lo", lo_out, 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        last_lo = '0;
        last_hi = '0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000 | $urandom;
                4: begin
                    a = 32'h8000_0000;
                    b = $urandom;
                end
                default: b = $urandom;
            endcase
            issue(sgn, a, b, 1'b1);
        end
        wait_done();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
